alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Producer side of the ALU control/operand interface: decodes OP, OP-IMM, LUI and AUIPC instructions into funct3/funct7/operand_1/operand_2.
//  Registers the decoded fields behind a valid/ready handshake with a 2-entry skid buffer.
//  Sits between register-file read and the IEU. Its outputs drive the ALU directly; rd goes to writeback.
// PARAMETERS
//  XLEN  32  datapath width (32 or 64); immediates sign-extended to XLEN
// PORTS
//  clk            in   1     single clock, rising edge
//  rst_n          in   1     reset, asynchronous assert, active-low
//  flush          in   1     synchronous pipeline flush
//  in_valid       in   1     upstream instruction valid
//  in_ready       out  1     stage can accept (registered)
//  in_instr       in   32    instruction word
//  in_pc          in   XLEN  instruction PC
//  in_rs1_data    in   XLEN  rs1 value
//  in_rs2_data    in   XLEN  rs2 value
//  out_valid      out  1     decoded op valid
//  out_ready      in   1     ALU/writeback accepts
//  out_funct3     out  3     ALU funct3
//  out_funct7     out  7     ALU funct7 (bit 5 = SUB/SRA select)
//  out_operand_1  out  XLEN  ALU operand 1
//  out_operand_2  out  XLEN  ALU operand 2
//  out_rd         out  5     destination register
//  out_illegal    out  1     illegal-instruction flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, in_ready=1, all out_* data=0, both entries empty.
//  Decode by opcode instr[6:0]:
//   0110011 OP: f3=instr[14:12], f7=instr[31:25], op1=rs1, op2=rs2.
//   0010011 OP-IMM: f3=instr[14:12], op1=rs1, op2=sext(instr[31:20]).
//    f7=instr[31:25] only when f3 is 001 or 101. Otherwise f7=0, so ADDI never becomes SUB.
//    If XLEN=64, f7[0]=0 (instr[25] is shamt[5]).
//   0110111 LUI: f3=000, f7=0, op1=0, op2=sext({instr[31:12],12'b0}).
//   0010111 AUIPC: f3=000, f7=0, op1=pc, op2=sext({instr[31:12],12'b0}).
//   rd=instr[11:7] always.
//  Illegal:
//   any other opcode;
//   OP with f7 not in {00,20};
//   OP with f7=20 and f3 not in {000,101};
//   OP-IMM f3=001 with f7!=0;
//   OP-IMM f3=101 with f7 not in {00,20}.
//  Handshake: transfer on valid&&ready at either side. Latency 1 cycle. Throughput 1/cycle.
//  out_* stay stable while out_valid && !out_ready.
//  States:
//   EMPTY: in_ready=1, out_valid=0.
//    in xfer -> MAIN.
//   MAIN: main reg holds 1 op, in_ready=1, out_valid=1.
//    in xfer & out xfer -> MAIN (new op).
//    in xfer & !out_ready -> SKID (new op into skid reg).
//    out xfer only -> EMPTY.
//   SKID: both regs held, in_ready=0.
//    out xfer -> MAIN, skid moves to main.
//  in_ready depends only on state, never combinationally on out_ready.
//  flush=1: next edge -> EMPTY, out_valid=0; any same-cycle input is dropped. Flush wins over all other events.
//  Reset mid-transfer discards both entries.
// CONFIGURATION
//  ALU_ILLEGAL_TRAP_EN defined:
//   Illegal instructions are forwarded as normal ops with out_illegal=1, f3=0, f7=0, op1=op2=0, rd=0.
//  ALU_ILLEGAL_TRAP_EN undefined:
//   Illegal instructions are accepted and silently discarded; no out_valid pulse.
//   out_illegal tied to 0.
// TESTING
//  1. ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, f3=0, f7=0, op1=5, op2=7, rd=3.
//  2. ADDI x1,x0,-1 (0xFFF00093) -> op2=0xFFFFFFFF, f7=0 (not SUB).
//     SRAI x1,x1,3 (0x4030D093) -> f3=101, f7=0x20, op2[4:0]=3.
//  3. AUIPC x5,0x12345 (0x12345297), pc=0x100 -> op1=0x100, op2=0x12345000.
//     LUI same imm (0x123452B7) -> op1=0.
//  4. Hold out_ready=0 while sending 3 back-to-back ops -> in_ready falls after the 2nd accept; 3rd held upstream.
//     Release -> ops emerge in order, none lost or duplicated.
//  5. Assert flush in SKID state with in_valid=1 -> next cycle out_valid=0, in_ready=1; flushed ops never appear.
//  6. Opcode 0x7F with ALU_ILLEGAL_TRAP_EN -> out_valid=1, out_illegal=1.
//     Without the macro -> no output; following ADD emerges normally.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Producer side of the ALU control/operand interface. Decodes OP, OP-IMM,
//   LUI and AUIPC instructions into funct3/funct7/operand_1/operand_2/rd and
//   presents them to the ALU behind a valid/ready handshake with a 2-entry
//   skid buffer (main register + skid register).
//
//   Optional feature macro: ALU_ILLEGAL_TRAP_EN
//     defined   : illegal instructions are forwarded as zeroed ops with
//                 out_illegal=1
//     undefined : illegal instructions are accepted and silently dropped;
//                 out_illegal is tied to 0
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   flush                 synchronous flush, empties both entries
//   in_valid/in_ready     upstream handshake (in_ready comes from state only)
//   in_instr/in_pc        instruction word and its PC
//   in_rs1_data/rs2_data  register-file read values
//   out_valid/out_ready   downstream handshake to ALU/writeback
//   out_funct3/funct7     ALU control
//   out_operand_1/2       ALU operands
//   out_rd                destination register
//   out_illegal           illegal-instruction flag
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_operand_1,
  output logic [XLEN-1:0] out_operand_2,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_MAIN,
    S_SKID
  } state_t;

  typedef struct packed {
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [4:0]      rd;
  } payload_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  state_t   state_q, state_d;
  payload_t main_q, skid_q, dec;
  logic     illegal;
  logic     in_xfer, out_xfer, accept;
  logic     ld_main, ld_skid, mv_skid;

  // Signed views of the immediates; width casts to XLEN sign-extend them.
  logic signed [11:0] imm_i;
  logic signed [31:0] imm_u;
  logic [2:0]         f3_raw;
  logic [6:0]         f7_raw;

  assign imm_i  = in_instr[31:20];
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign f3_raw = in_instr[14:12];
  assign f7_raw = in_instr[31:25];

  // ---------------------------------------------------------------- decode
  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    dec.rd  = in_instr[11:7];
    case (in_instr[6:0])
      OPC_OP: begin
        dec.f3  = f3_raw;
        dec.f7  = f7_raw;
        dec.op1 = in_rs1_data;
        dec.op2 = in_rs2_data;
        illegal = !((f7_raw == 7'h00) ||
                    (f7_raw == 7'h20 && (f3_raw == 3'b000 || f3_raw == 3'b101)));
      end
      OPC_OP_IMM: begin
        dec.f3  = f3_raw;
        dec.op1 = in_rs1_data;
        dec.op2 = XLEN'(imm_i);
        // Only shifts carry funct7; other OP-IMM forms keep it zero so the
        // immediate's upper bits never select SUB.
        if (f3_raw == 3'b001 || f3_raw == 3'b101) begin
          dec.f7 = f7_raw;
          if (XLEN == 64) dec.f7[0] = 1'b0;  // instr[25] is shamt[5]
        end
        illegal = (f3_raw == 3'b001 && dec.f7 != 7'h00) ||
                  (f3_raw == 3'b101 && dec.f7 != 7'h00 && dec.f7 != 7'h20);
      end
      OPC_LUI: begin
        dec.op2 = XLEN'(imm_u);
      end
      OPC_AUIPC: begin
        dec.op1 = in_pc;
        dec.op2 = XLEN'(imm_u);
      end
      default: illegal = 1'b1;
    endcase
`ifdef ALU_ILLEGAL_TRAP_EN
    if (illegal) dec = '0;
`endif
  end

  // ------------------------------------------------------------ handshake
  assign in_ready  = (state_q != S_SKID);
  assign out_valid = (state_q != S_EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

`ifdef ALU_ILLEGAL_TRAP_EN
  assign accept = in_xfer;
`else
  // Illegal ops complete the input handshake but never occupy an entry.
  assign accept = in_xfer && !illegal;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            ld_main = 1'b1;
            state_d = S_MAIN;
          end
        end
        S_MAIN: begin
          if (out_xfer && accept) begin
            ld_main = 1'b1;
          end else if (out_xfer) begin
            state_d = S_EMPTY;
          end else if (accept) begin
            ld_skid = 1'b1;
            state_d = S_SKID;
          end
        end
        S_SKID: begin
          if (out_xfer) begin
            mv_skid = 1'b1;
            state_d = S_MAIN;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main)      main_q <= dec;
      else if (mv_skid) main_q <= skid_q;
      if (ld_skid)      skid_q <= dec;
    end
  end

`ifdef ALU_ILLEGAL_TRAP_EN
  logic main_ill_q, skid_ill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_ill_q <= 1'b0;
      skid_ill_q <= 1'b0;
    end else begin
      if (ld_main)      main_ill_q <= illegal;
      else if (mv_skid) main_ill_q <= skid_ill_q;
      if (ld_skid)      skid_ill_q <= illegal;
    end
  end

  assign out_illegal = main_ill_q;
`else
  assign out_illegal = 1'b0;
`endif

  assign out_funct3    = main_q.f3;
  assign out_funct7    = main_q.f7;
  assign out_operand_1 = main_q.op1;
  assign out_operand_2 = main_q.op2;
  assign out_rd        = main_q.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage (XLEN=32). A FIFO-level model
// (at most two pending decoded ops) predicts the outputs every cycle; directed
// vectors add hand-computed literal checks. Honours ALU_ILLEGAL_TRAP_EN.
module tb_alu_issue_stage;
  localparam int XLEN = 32;
`ifdef ALU_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic            clk, rst_n, flush;
  logic            in_valid, in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc, in_rs1_data, in_rs2_data;
  logic            out_valid, out_ready;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_operand_1, out_operand_2;
  logic [4:0]      out_rd;
  logic            out_illegal;

  alu_issue_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_operand_1(out_operand_1), .out_operand_2(out_operand_2),
    .out_rd(out_rd), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  logic [4:0]  rd_log[$];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    end
  endtask

  // Decode from the ISA rules; returns 0 when the op must be dropped.
  function automatic bit model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] rs1, input logic [31:0] rs2,
                                      output exp_t e);
    bit legal = 1'b1;
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    e = '0;
    e.rd = ins[11:7];
    case (ins[6:0])
      7'h33: begin
        e.f3 = f3; e.f7 = f7; e.op1 = rs1; e.op2 = rs2;
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'h13: begin
        e.f3 = f3; e.op1 = rs1; e.op2 = {{20{ins[31]}}, ins[31:20]};
        if (f3 == 3'd1 || f3 == 3'd5) e.f7 = f7;
        if (f3 == 3'd1 && e.f7 != 0) legal = 1'b0;
        if (f3 == 3'd5 && e.f7 != 0 && e.f7 != 7'h20) legal = 1'b0;
      end
      7'h37: e.op2 = {ins[31:12], 12'h000};
      7'h17: begin e.op1 = pc; e.op2 = {ins[31:12], 12'h000}; end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e = '0;
      e.ill = 1'b1;
      return TRAP;
    end
    return 1'b1;
  endfunction

  // Model: a queue of at most two ops; input accepted while fewer than two.
  bit   m_in, m_out, m_keep;
  exp_t m_e;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      m_in  = in_valid && (q.size() < 2);
      m_out = out_ready && (q.size() > 0);
      if (flush) begin
        q.delete();
      end else begin
        if (m_out) void'(q.pop_front());
        if (m_in) begin
          m_keep = model_decode(in_instr, in_pc, in_rs1_data, in_rs2_data, m_e);
          if (m_keep) q.push_back(m_e);
        end
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (q.size() > 0) begin
        chk("funct3", 64'(out_funct3), 64'(q[0].f3));
        chk("funct7", 64'(out_funct7), 64'(q[0].f7));
        chk("operand_1", 64'(out_operand_1), 64'(q[0].op1));
        chk("operand_2", 64'(out_operand_2), 64'(q[0].op2));
        chk("rd", 64'(out_rd), 64'(q[0].rd));
        chk("illegal", 64'(out_illegal), 64'(q[0].ill));
      end
      if (out_valid && out_ready) rd_log.push_back(out_rd);
    end
  end

  // Driver runs 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    in_rs1_data = rs1; in_rs2_data = rs2;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] rs2);
    int n = 0;
    set_in(ins, pc, rs1, rs2);
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_ready stayed 0 instr=%h", ins);
    end
    tick();
    in_valid = 1'b0;
  endtask

  logic [31:0] vec [10] = '{32'h402081B3, 32'h402091B3, 32'h40309093, 32'h00309093,
                            32'hFFF0C093, 32'h0030D093, 32'h4030D093, 32'h020081B3,
                            32'h4020D1B3, 32'hFFFFF0B7};

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_funct3", 64'(out_funct3), 64'd0);
    chk("rst_funct7", 64'(out_funct7), 64'd0);
    chk("rst_op1", 64'(out_operand_1), 64'd0);
    chk("rst_op2", 64'(out_operand_2), 64'd0);
    chk("rst_rd", 64'(out_rd), 64'd0);
    chk("rst_illegal", 64'(out_illegal), 64'd0);
    rst_n = 1'b1;
    tick();

    // ADD x3,x1,x2
    send(32'h002081B3, 32'h0, 32'd5, 32'd7);
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_f3", 64'(out_funct3), 64'd0);
    chk("add_f7", 64'(out_funct7), 64'd0);
    chk("add_op1", 64'(out_operand_1), 64'd5);
    chk("add_op2", 64'(out_operand_2), 64'd7);
    chk("add_rd", 64'(out_rd), 64'd3);

    // ADDI x1,x0,-1 and SRAI x1,x1,3
    send(32'hFFF00093, 32'h0, 32'h0, 32'h0);
    chk("addi_op2", 64'(out_operand_2), 64'hFFFF_FFFF);
    chk("addi_f7", 64'(out_funct7), 64'd0);
    send(32'h4030D093, 32'h0, 32'h8000_0000, 32'h0);
    chk("srai_f3", 64'(out_funct3), 64'd5);
    chk("srai_f7", 64'(out_funct7), 64'h20);
    chk("srai_shamt", 64'(out_operand_2[4:0]), 64'd3);

    // AUIPC / LUI
    send(32'h12345297, 32'h100, 32'hAA, 32'hBB);
    chk("auipc_op1", 64'(out_operand_1), 64'h100);
    chk("auipc_op2", 64'(out_operand_2), 64'h1234_5000);
    chk("auipc_rd", 64'(out_rd), 64'd5);
    send(32'h123452B7, 32'h100, 32'hAA, 32'hBB);
    chk("lui_op1", 64'(out_operand_1), 64'd0);
    chk("lui_op2", 64'(out_operand_2), 64'h1234_5000);

    // Mixed legal/illegal batch with intermittent backpressure
    for (int i = 0; i < 10; i++) begin
      out_ready = (i % 3 != 1);
      send(vec[i], 32'h1000 + 32'(i * 4), 32'h1111_0000 + 32'(i), 32'hF000_0000 - 32'(i));
    end
    out_ready = 1'b1;
    tick(); tick(); tick();

    // Back-to-back under backpressure: third op held upstream
    rd_log.delete();
    out_ready = 1'b0;
    send(32'h00208533, 32'h0, 32'd1, 32'd2);
    send(32'h002085B3, 32'h0, 32'd3, 32'd4);
    chk("skid_in_ready", 64'(in_ready), 64'd0);
    set_in(32'h00208633, 32'h0, 32'd5, 32'd6);
    tick(); tick();
    chk("held_in_ready", 64'(in_ready), 64'd0);
    chk("held_rd", 64'(out_rd), 64'd10);
    out_ready = 1'b1;
    send(32'h00208633, 32'h0, 32'd5, 32'd6);
    tick(); tick(); tick();
    chk("order_count", 64'(rd_log.size()), 64'd3);
    chk("order_0", 64'(rd_log[0]), 64'd10);
    chk("order_1", 64'(rd_log[1]), 64'd11);
    chk("order_2", 64'(rd_log[2]), 64'd12);

    // Flush in SKID with a same-cycle input
    out_ready = 1'b0;
    send(32'h00208533, 32'h0, 32'd1, 32'd2);
    send(32'h002085B3, 32'h0, 32'd3, 32'd4);
    set_in(32'h00208633, 32'h0, 32'd5, 32'd6);
    flush = 1'b1;
    tick();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    flush = 1'b0;
    in_valid = 1'b0;
    rd_log.delete();
    out_ready = 1'b1;
    send(32'h002086B3, 32'h0, 32'd7, 32'd8);
    tick(); tick();
    chk("post_flush_count", 64'(rd_log.size()), 64'd1);
    chk("post_flush_rd", 64'(rd_log[0]), 64'd13);

    // Reset while both entries are held
    out_ready = 1'b0;
    send(32'h00208533, 32'h0, 32'd1, 32'd2);
    send(32'h002085B3, 32'h0, 32'd3, 32'd4);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_op1", 64'(out_operand_1), 64'd0);
    tick();
    rst_n = 1'b1;
    rd_log.delete();
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("midrst_nothing_out", 64'(rd_log.size()), 64'd0);

    // Illegal opcode 0x7F (rd field = 31)
    send(32'h00000FFF, 32'h0, 32'd9, 32'd9);
`ifdef ALU_ILLEGAL_TRAP_EN
    chk("trap_valid", 64'(out_valid), 64'd1);
    chk("trap_illegal", 64'(out_illegal), 64'd1);
    chk("trap_rd", 64'(out_rd), 64'd0);
    chk("trap_op1", 64'(out_operand_1), 64'd0);
`else
    chk("drop_valid", 64'(out_valid), 64'd0);
    chk("drop_illegal", 64'(out_illegal), 64'd0);
`endif
    send(32'h002081B3, 32'h0, 32'd1, 32'd2);
    chk("after_ill_valid", 64'(out_valid), 64'd1);
    chk("after_ill_op1", 64'(out_operand_1), 64'd1);
    chk("after_ill_rd", 64'(out_rd), 64'd3);
    chk("after_ill_flag", 64'(out_illegal), 64'd0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
